// File: rtl/vec_issue_if.sv
// Scalar-to-vector issue channel: enqueue side from the scalar core,
// issue/ack side to the vector processor, plus occupancy and retire status.
interface vec_issue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_inst;
  logic [XLEN-1:0] enq_rs1;
  logic [XLEN-1:0] enq_rs2;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            inst_valid;
  logic            vec_pro_ready;
  logic            scalar_pro_ready;
  logic            vec_pro_ack;
  logic [CW-1:0]   count;
  logic            retire_pulse;
  logic [15:0]     retire_cnt;

  // Environment side: offers entries and plays the vector processor.
  modport master (
    output enq_valid, enq_inst, enq_rs1, enq_rs2, vec_pro_ready, vec_pro_ack,
    input  enq_ready, instruction, rs1_data, rs2_data, inst_valid,
           scalar_pro_ready, count, retire_pulse, retire_cnt
  );

  // Queue side.
  modport slave (
    input  enq_valid, enq_inst, enq_rs1, enq_rs2, vec_pro_ready, vec_pro_ack,
    output enq_ready, instruction, rs1_data, rs2_data, inst_valid,
           scalar_pro_ready, count, retire_pulse, retire_cnt
  );
endinterface

// File: rtl/vec_issue_queue.sv
// Vector issue queue: circular FIFO of {inst, rs1, rs2} feeding a vector
// processor one instruction at a time, waiting for each completion ack
// before issuing the next.
module vec_issue_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  vec_issue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  state_t          state;
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] rs1_mem  [DEPTH];
  logic [XLEN-1:0] rs2_mem  [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            issue_q;
  logic            wait_q;
  logic            pulse_q;
  logic [15:0]     retire_q;
  logic            has_entry;
  logic            push;
  logic            pop;

  // Acceptance looks only at the registered count, so a pop on the same
  // edge never frees a slot for an entry offered while full.
  assign has_entry     = (count != '0);
  assign bus.enq_ready = reset & (count < FULL);
  assign push          = bus.enq_valid & bus.enq_ready;
  assign pop           = reset & issue_q & bus.vec_pro_ready;

  // Status flags are forced low while reset is held, even before the edge.
  assign bus.inst_valid       = reset & issue_q;
  assign bus.scalar_pro_ready = reset & wait_q;
  assign bus.retire_pulse     = reset & pulse_q;
  assign bus.retire_cnt       = retire_q;
  assign bus.count            = count;

  // Head entry is always visible; an empty queue shows zeros.
  assign bus.instruction = has_entry ? inst_mem[head] : '0;
  assign bus.rs1_data    = has_entry ? rs1_mem[head]  : '0;
  assign bus.rs2_data    = has_entry ? rs2_mem[head]  : '0;

  // Entry storage: written on enqueue only; contents are don't-care when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail] <= bus.enq_inst;
      rs1_mem[tail]  <= bus.enq_rs1;
      rs2_mem[tail]  <= bus.enq_rs2;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth gives natural wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM: one outstanding instruction, registered valid/ready/retire outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      issue_q  <= 1'b0;
      wait_q   <= 1'b0;
      pulse_q  <= 1'b0;
      retire_q <= '0;
    end else begin
      pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (has_entry) begin
            state   <= ISSUE;
            issue_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.vec_pro_ready) begin
            state   <= WAIT_ACK;
            issue_q <= 1'b0;
            wait_q  <= 1'b1;
          end
        end
        WAIT_ACK: begin
          if (bus.vec_pro_ack) begin
            state    <= IDLE;
            wait_q   <= 1'b0;
            pulse_q  <= 1'b1;
            retire_q <= retire_q + 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          issue_q <= 1'b0;
          wait_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vec_issue_queue.sv
// Bench for vec_issue_queue: directed scenarios plus randomized traffic,
// with a queue-based reference model checked by a negedge monitor.
module tb_vec_issue_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } entry_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  vec_issue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  vec_issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  entry_t      exp_q[$];
  logic        outstanding = 1'b0;
  logic        pulse_due   = 1'b0;
  logic [15:0] exp_retire  = 16'd0;
  bit          auto_mode   = 1'b0;
  bit          rnd_enq     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model + monitor: FIFO of accepted entries, one outstanding issue.
  always @(negedge clk) begin
    entry_t hd;
    bit     acc;
    if (!reset) begin
      chk("rst_inst_valid", 32'(bus.inst_valid), 0);
      chk("rst_scalar_ready", 32'(bus.scalar_pro_ready), 0);
      chk("rst_enq_ready", 32'(bus.enq_ready), 0);
      exp_q.delete();
      outstanding = 1'b0;
      pulse_due   = 1'b0;
      exp_retire  = 16'd0;
    end else begin
      hd  = (exp_q.size() != 0) ? exp_q[0] : '0;
      acc = (exp_q.size() < DEPTH);
      chk("count", 32'(bus.count), exp_q.size());
      chk("enq_ready", 32'(bus.enq_ready), 32'(acc));
      chk("instruction", bus.instruction, hd.inst);
      chk("rs1_data", bus.rs1_data, hd.rs1);
      chk("rs2_data", bus.rs2_data, hd.rs2);
      chk("scalar_pro_ready", 32'(bus.scalar_pro_ready), 32'(outstanding));
      chk("single_outstanding", 32'(bus.inst_valid & outstanding), 0);
      chk("retire_pulse", 32'(bus.retire_pulse), 32'(pulse_due));
      chk("retire_cnt", 32'(bus.retire_cnt), 32'(exp_retire));
      pulse_due = 1'b0;
      if (outstanding && bus.vec_pro_ack) begin
        outstanding = 1'b0;
        exp_retire++;
        pulse_due = 1'b1;
      end else if (bus.inst_valid && bus.vec_pro_ready) begin
        chk("issue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        outstanding = 1'b1;
      end
      if (bus.enq_valid && acc)
        exp_q.push_back({bus.enq_inst, bus.enq_rs1, bus.enq_rs2});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_mode) begin
      bus.vec_pro_ready = 1'($urandom_range(0, 1));
      bus.vec_pro_ack   = ($urandom_range(0, 3) == 0);
    end
    if (rnd_enq) begin
      bus.enq_valid = ($urandom_range(0, 2) != 0);
      bus.enq_inst  = $urandom;
      bus.enq_rs1   = $urandom;
      bus.enq_rs2   = $urandom;
    end
  endtask

  task automatic set_entry(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
    bus.enq_valid = 1'b1;
    bus.enq_inst  = inst;
    bus.enq_rs1   = rs1;
    bus.enq_rs2   = rs2;
  endtask

  task automatic drain();
    int w = 0;
    auto_mode     = 1'b1;
    bus.enq_valid = 1'b0;
    while ((exp_q.size() != 0 || outstanding) && w < 500) begin
      step();
      w++;
    end
    chk("drain", exp_q.size() + 32'(outstanding), 0);
  endtask

  initial begin
    bus.enq_valid     = 1'b0;
    bus.enq_inst      = '0;
    bus.enq_rs1       = '0;
    bus.enq_rs2       = '0;
    bus.vec_pro_ready = 1'b0;
    bus.vec_pro_ack   = 1'b0;
    reset             = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_retire_cnt", 32'(bus.retire_cnt), 0);
    chk("reset_inst_valid", 32'(bus.inst_valid), 0);

    // Single instruction, immediate ready, ack two cycles after issue.
    bus.vec_pro_ready = 1'b1;
    set_entry(32'h0C0071D7, 32'd16, 32'd0);
    step();
    bus.enq_valid = 1'b0;
    chk("lat_not_yet_valid", 32'(bus.inst_valid), 0);
    chk("lat_count1", 32'(bus.count), 1);
    step();
    chk("lat_inst_valid", 32'(bus.inst_valid), 1);
    chk("lat_instruction", bus.instruction, 32'h0C0071D7);
    chk("lat_rs1", bus.rs1_data, 32'd16);
    chk("lat_rs2", bus.rs2_data, 32'd0);
    step();
    chk("one_cycle_valid", 32'(bus.inst_valid), 0);
    chk("wait_scalar_ready", 32'(bus.scalar_pro_ready), 1);
    chk("popped_count", 32'(bus.count), 0);
    step();
    bus.vec_pro_ack = 1'b1;
    step();
    bus.vec_pro_ack   = 1'b0;
    bus.vec_pro_ready = 1'b0;
    chk("first_retire_pulse", 32'(bus.retire_pulse), 1);
    chk("first_retire_cnt", 32'(bus.retire_cnt), 1);

    // Five back-to-back offers with the processor stalled: fifth refused.
    for (int i = 0; i < 5; i++) begin
      set_entry(32'hA000_0000 + 32'(i), 32'h100 + 32'(i), 32'h200 + 32'(i));
      step();
    end
    bus.enq_valid = 1'b0;
    chk("full_count", 32'(bus.count), 4);

    // Stall in ISSUE for ten cycles: outputs hold, nothing pops.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_valid", 32'(bus.inst_valid), 1);
      chk("stall_inst", bus.instruction, 32'hA000_0000);
      chk("stall_count", 32'(bus.count), 4);
    end

    // Ack while in ISSUE is ignored.
    bus.vec_pro_ack = 1'b1;
    step();
    bus.vec_pro_ack = 1'b0;
    step();
    chk("early_ack_valid", 32'(bus.inst_valid), 1);
    chk("early_ack_retire", 32'(bus.retire_cnt), 1);

    // Enqueue on the same edge as a pop while full: rejected.
    set_entry(32'hB000_0000, 32'h1, 32'h2);
    bus.vec_pro_ready = 1'b1;
    step();
    bus.enq_valid     = 1'b0;
    bus.vec_pro_ready = 1'b0;
    chk("pop_full_count", 32'(bus.count), 3);
    chk("pop_full_wait", 32'(bus.scalar_pro_ready), 1);
    set_entry(32'hB000_0001, 32'h3, 32'h4);
    step();
    bus.enq_valid = 1'b0;
    chk("refill_count", 32'(bus.count), 4);

    // Eight sequential entries under random ready/ack: wrap and FIFO order.
    auto_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int w = 0;
      bit acc;
      set_entry(32'hC000_0000 + 32'(i), 32'h300 + 32'(i), 32'h400 + 32'(i));
      do begin
        acc = bus.enq_ready;
        step();
        w++;
      end while (!acc && w < 100);
      chk("seq_accept", 32'(acc), 1);
    end
    drain();

    // Reset while waiting for an ack with three entries queued.
    auto_mode         = 1'b0;
    bus.vec_pro_ready = 1'b0;
    bus.vec_pro_ack   = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      set_entry(32'hD000_0000 + 32'(i), 32'h500 + 32'(i), 32'h600 + 32'(i));
      step();
    end
    bus.enq_valid = 1'b0;
    chk("pre_reset_issue", 32'(bus.inst_valid), 1);
    bus.vec_pro_ready = 1'b1;
    step();
    bus.vec_pro_ready = 1'b0;
    chk("pre_reset_wait", 32'(bus.scalar_pro_ready), 1);
    chk("pre_reset_count", 32'(bus.count), 3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_inst_valid", 32'(bus.inst_valid), 0);
    chk("midrst_scalar_ready", 32'(bus.scalar_pro_ready), 0);
    chk("midrst_retire_cnt", 32'(bus.retire_cnt), 0);
    bus.vec_pro_ack = 1'b1;
    step();
    bus.vec_pro_ack = 1'b0;
    chk("late_ack_pulse", 32'(bus.retire_pulse), 0);
    step();
    chk("late_ack_pulse2", 32'(bus.retire_pulse), 0);
    chk("late_ack_retire", 32'(bus.retire_cnt), 0);

    // Randomized traffic against the reference model.
    auto_mode = 1'b1;
    rnd_enq   = 1'b1;
    repeat (1500) step();
    rnd_enq = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
